matmul_result_drain: RTL
========================

MATMUL_RESULT_DRAIN -- requirements
Module: matmul_result_drain

Interface
REQ-001 Parameter M, default 8, number of result rows.
REQ-002 Parameter P, default 8, number of result columns.
REQ-003 Parameter RESULT_WIDTH, default 16, width of each signed accumulator result.
REQ-004 Parameter OUT_WIDTH, default 8, width of each signed quantized output element.
REQ-005 Parameter ADDR_WIDTH, default 10, width of the destination address.
REQ-006 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 Port done, input, 1 bit: one-cycle pulse from the matrix multiplier marking result_c valid.
REQ-009 Port result_c, input, M*P*RESULT_WIDTH bits: packed results; element k=i*P+j at bits [k*RESULT_WIDTH +: RESULT_WIDTH].
REQ-010 Port shift, input, 4 bits: requantization right-shift amount, 0..15.
REQ-011 Port base_addr, input, ADDR_WIDTH bits: destination address of element 0.
REQ-012 Port out_valid, output, 1 bit: out_data/out_addr/out_last hold a valid element.
REQ-013 Port out_ready, input, 1 bit: consumer accepts the element this cycle.
REQ-014 Port out_data, output, OUT_WIDTH bits: signed quantized element.
REQ-015 Port out_addr, output, ADDR_WIDTH bits: destination address for out_data (drives BRAM addr; out_valid&out_ready drives we).
REQ-016 Port out_last, output, 1 bit: current element is k=M*P-1.
REQ-017 Port busy, output, 1 bit: high while in DRAIN.
REQ-018 Port sat_count, output, 8 bits: number of saturated elements in the current/last drain.
REQ-019 Port drop_err, output, 1 bit: sticky; a done pulse was ignored.

Function
REQ-020 Two states, IDLE and DRAIN; the state register and all outputs are cleared by reset.
REQ-021 In IDLE with done=1, the block shall snapshot result_c, shift and base_addr into internal registers, clear k to 0, clear sat_count, and enter DRAIN.
REQ-022 out_valid shall rise on the clock edge that samples done (first element visible the cycle after the done pulse).
REQ-023 While in DRAIN, out_valid=1 and busy=1; element k derives only from snapshot registers, so result_c may change after the done pulse.
REQ-024 Transfer occurs when out_valid&out_ready; without a transfer out_data, out_addr and out_last shall remain stable.
REQ-025 On a transfer with k<M*P-1, k increments and the next element is presented the following cycle (one element per cycle at full throughput).
REQ-026 On a transfer with k=M*P-1 (out_last=1), the block returns to IDLE; out_valid and busy drop the next cycle.
REQ-027 Quantization: x = snapshot element k (signed); if shift>0, r = (x + 2^(shift-1)) >>> shift computed in RESULT_WIDTH+1 bits (no wrap); if shift=0, r = x.
REQ-028 Saturation: out_data = clamp(r, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1); each clamped element increments sat_count once on its transfer, sticking at 255.
REQ-029 out_addr = (base_addr + k) mod 2^ADDR_WIDTH; the address wraps past all-ones to 0.
REQ-030 A done pulse arriving in DRAIN, including the cycle of the final transfer, shall be ignored and shall set drop_err.
REQ-031 drop_err shall clear only on reset.
REQ-032 out_ready is ignored in IDLE; out_data, out_addr and out_last shall be 0 in IDLE.

Reset
REQ-033 While rst=1: state=IDLE, out_valid=0, out_last=0, busy=0, out_data=0, out_addr=0, sat_count=0, drop_err=0, k=0.
REQ-034 Reset asserted mid-DRAIN shall abort the drain immediately; no further elements shall be emitted after release until a new done pulse.

Verification
REQ-035 M=P=8, all results 100, shift=0, base_addr=0, out_ready=1, one done pulse -> 64 consecutive transfers of 100, addrs 0..63, out_last only on the 64th, sat_count=0, busy low the cycle after the 64th.
REQ-036 Results {300, -300, 127, -129}, shift=0 -> out_data {127, -128, 127, -128}, sat_count=3.
REQ-037 Results {6, 5, -6, 32767}, shift=2 -> out_data {2, 1, -1, 127}; 32767 must not wrap negative during rounding.
REQ-038 base_addr=1020, ADDR_WIDTH=10 -> out_addr 1020..1023, then 0..59.
REQ-039 out_ready toggled pseudo-randomly, result_c changed after done -> data/addr stable while stalled; emitted sequence equals the snapshot; second done mid-drain -> drop_err=1, no restart.
REQ-040 rst pulsed after 10 transfers -> all outputs 0, out_valid stays 0 after release until the next done.

Source files
------------

// File: rtl/matmul_result_drain.sv
// matmul_result_drain: snapshots a finished result matrix and streams requantized, saturated elements with addresses.
module matmul_result_drain #(
  parameter int M = 8,
  parameter int P = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         done,
  input  logic [M*P*RESULT_WIDTH-1:0]  result_c,
  input  logic [3:0]                   shift,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic                         out_last,
  output logic                         busy,
  output logic [7:0]                   sat_count,
  output logic                         drop_err
);
  localparam int N = M * P;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic signed [RESULT_WIDTH:0] MAXV = (RESULT_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RESULT_WIDTH:0] MINV = ~MAXV;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state;
  logic [N*RESULT_WIDTH-1:0] snap;
  logic [3:0] shift_r, sh;
  logic [KW-1:0] k;
  logic out_sat, sat, nl;
  int idx;
  logic [RESULT_WIDTH-1:0] x;
  logic signed [RESULT_WIDTH:0] xe, rnd, r;
  logic [OUT_WIDTH-1:0] q;
  // The next element to present: element 0 straight from the input on done, otherwise k+1 from the snapshot.
  always_comb begin
    idx = (state == IDLE || int'(k) == N - 1) ? 0 : int'(k) + 1;
    nl = state == IDLE ? N == 1 : int'(k) + 1 == N - 1;
    sh = state == IDLE ? shift : shift_r;
    x = state == IDLE ? result_c[idx*RESULT_WIDTH +: RESULT_WIDTH] : snap[idx*RESULT_WIDTH +: RESULT_WIDTH];
    xe = {x[RESULT_WIDTH-1], x};
    rnd = sh == 4'd0 ? '0 : (RESULT_WIDTH+1)'(1) << (sh - 4'd1);
    r = (xe + rnd) >>> sh;
    sat = r > MAXV || r < MINV;
    q = r > MAXV ? MAXV[OUT_WIDTH-1:0] : r < MINV ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      shift_r <= '0;
      k <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
      out_sat <= 1'b0;
      busy <= 1'b0;
      sat_count <= '0;
      drop_err <= 1'b0;
    end else if (state == IDLE) begin
      if (done) begin
        state <= DRAIN;
        snap <= result_c;
        shift_r <= shift;
        k <= '0;
        sat_count <= '0;
        out_valid <= 1'b1;
        busy <= 1'b1;
        out_data <= q;
        out_addr <= base_addr;
        out_last <= nl;
        out_sat <= sat;
      end
    end else begin
      if (done) drop_err <= 1'b1;
      if (out_ready) begin
        if (out_sat && sat_count != 8'hff) sat_count <= sat_count + 8'd1;
        if (out_last) begin
          state <= IDLE;
          k <= '0;
          out_valid <= 1'b0;
          busy <= 1'b0;
          out_data <= '0;
          out_addr <= '0;
          out_last <= 1'b0;
          out_sat <= 1'b0;
        end else begin
          k <= k + KW'(1);
          out_data <= q;
          out_addr <= out_addr + ADDR_WIDTH'(1);
          out_last <= nl;
          out_sat <= sat;
        end
      end
    end
  end
endmodule
